conv3x3_rgb888: RTL and testbench



---
 rtl/conv3x3_rgb888_pkg.sv | 41 ++++
 rtl/conv3x3_rgb888_if.sv | 32 +++
 rtl/conv3x3_rgb888_channel.sv | 52 +++++
 rtl/conv3x3_rgb888.sv | 98 +++++++++
 tb/tb_conv3x3_rgb888.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv3x3_rgb888_pkg.sv
// Shared constants and helpers for the 3x3 RGB888 convolution block.
package conv3x3_rgb888_pkg;

  localparam int PIX_W      = 8;
  localparam int COEF_W     = 8;
  localparam int NTAP       = 9;
  localparam int CENTRE_TAP = 4;
  localparam int KERN_W     = NTAP * COEF_W;

  // 9-bit zero-extended pixel x 8-bit signed coef, then row and frame sums.
  localparam int PROD_W = 17;
  localparam int PART_W = 19;
  localparam int SUM_W  = 21;

  localparam int R_MSB = 23;
  localparam int R_LSB = 16;
  localparam int G_MSB = 15;
  localparam int G_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;

  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(255);

  // Kernel that passes the centre pixel through unchanged after the shift.
  function automatic logic [KERN_W-1:0] identity_kernel(input int unsigned shift);
    logic [KERN_W-1:0] k;
    k = '0;
    k[CENTRE_TAP*COEF_W +: COEF_W] = COEF_W'(32'd1 << shift);
    return k;
  endfunction

  // Clamp a signed sum into the unsigned 0..255 channel range.
  function automatic logic [PIX_W-1:0] sat_u8(input logic signed [SUM_W-1:0] x);
    logic [PIX_W-1:0] y;
    if (x < 0)            y = '0;
    else if (x > SAT_MAX) y = '1;
    else                  y = x[PIX_W-1:0];
    return y;
  endfunction

endpackage

// File: rtl/conv3x3_rgb888_if.sv
// Window-in / pixel-out bus of the convolution block.
// Valid semantics: a window is taken on every clock edge where iEn=1 and
// iValid=1; oValid=1 means oPixel/oAddr are to be written on that same edge.
// There is no ready: the producer never waits and the BRAM always accepts.
interface conv3x3_rgb888_if
  import conv3x3_rgb888_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 17
);
  logic              iEn;
  logic              iValid;
  logic [DATA_W-1:0] iWin0, iWin1, iWin2, iWin3, iWin4, iWin5, iWin6, iWin7, iWin8;
  logic              iCoefWe;
  logic [KERN_W-1:0] iCoef;
  logic [DATA_W-1:0] oPixel;
  logic              oValid;
  logic [ADDR_W-1:0] oAddr;
  logic              oFrameDone;

  modport master (
    output iEn, iValid, iWin0, iWin1, iWin2, iWin3, iWin4, iWin5, iWin6, iWin7, iWin8,
    output iCoefWe, iCoef,
    input  oPixel, oValid, oAddr, oFrameDone
  );

  modport slave (
    input  iEn, iValid, iWin0, iWin1, iWin2, iWin3, iWin4, iWin5, iWin6, iWin7, iWin8,
    input  iCoefWe, iCoef,
    output oPixel, oValid, oAddr, oFrameDone
  );
endinterface

// File: rtl/conv3x3_rgb888_channel.sv
// One 8-bit channel of the 3x3 convolution: multiply, row sums, final sum,
// shift and saturate, each stage registered and advancing only on i_adv.
module conv3x3_rgb888_channel
  import conv3x3_rgb888_pkg::*;
#(
  parameter int SHIFT = 4
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   i_adv,
  input  logic [NTAP*PIX_W-1:0]  i_pix,
  input  logic [KERN_W-1:0]      i_coef,
  output logic [PIX_W-1:0]       o_pix
);

  logic signed [PROD_W-1:0] w_prod [NTAP];
  logic signed [PROD_W-1:0] r_prod [NTAP];
  logic signed [PART_W-1:0] w_row  [3];
  logic signed [PART_W-1:0] r_row  [3];
  logic signed [SUM_W-1:0]  w_sum;
  logic signed [SUM_W-1:0]  w_shift;
  logic        [PIX_W-1:0]  r_pix;

  // Products, row partials and the normalised final sum.
  always_comb begin
    for (int t = 0; t < NTAP; t++) begin
      w_prod[t] = PROD_W'($signed({1'b0, i_pix[t*PIX_W +: PIX_W]}))
                * PROD_W'($signed(i_coef[t*COEF_W +: COEF_W]));
    end
    for (int r = 0; r < 3; r++) begin
      w_row[r] = PART_W'(r_prod[3*r]) + PART_W'(r_prod[3*r+1]) + PART_W'(r_prod[3*r+2]);
    end
    w_sum   = SUM_W'(r_row[0]) + SUM_W'(r_row[1]) + SUM_W'(r_row[2]);
    w_shift = w_sum >>> SHIFT;
  end

  // Three pipeline registers; everything holds while i_adv is low.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      for (int t = 0; t < NTAP; t++) r_prod[t] <= '0;
      for (int r = 0; r < 3; r++)    r_row[r]  <= '0;
      r_pix <= '0;
    end else if (i_adv) begin
      for (int t = 0; t < NTAP; t++) r_prod[t] <= w_prod[t];
      for (int r = 0; r < 3; r++)    r_row[r]  <= w_row[r];
      r_pix <= sat_u8(w_shift);
    end
  end

  assign o_pix = r_pix;

endmodule

// File: rtl/conv3x3_rgb888.sv
// 3x3 RGB888 convolution: shared kernel on R/G/B, 3-stage pipeline, raster
// write address and end-of-frame pulse for the output frame buffer.
module conv3x3_rgb888 #(
  parameter int DATA_W = 24,
  parameter int COEF_W = 8,
  parameter int ADDR_W = 17,
  parameter int WIDTH  = 480,
  parameter int HEIGHT = 272,
  parameter int SHIFT  = 4
) (
  input  logic              iClk,
  input  logic              iRst,
  conv3x3_rgb888_if.slave   bus
);
  import conv3x3_rgb888_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

  logic [9*COEF_W-1:0]     r_coef;
  logic                    r_v1, r_v2, r_v3;
  logic [ADDR_W-1:0]       r_addr;
  logic [DATA_W-1:0]       w_win [NTAP];
  logic [NTAP*PIX_W-1:0]   w_r, w_g, w_b;
  logic [PIX_W-1:0]        w_pix_r, w_pix_g, w_pix_b;
  logic [DATA_W-1:0]       w_pixel;
  logic                    w_adv, w_wr, w_last;

  assign w_win[0] = bus.iWin0;
  assign w_win[1] = bus.iWin1;
  assign w_win[2] = bus.iWin2;
  assign w_win[3] = bus.iWin3;
  assign w_win[4] = bus.iWin4;
  assign w_win[5] = bus.iWin5;
  assign w_win[6] = bus.iWin6;
  assign w_win[7] = bus.iWin7;
  assign w_win[8] = bus.iWin8;

  // Split the window into per-channel tap vectors (tap 0 in the low byte).
  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    for (int t = 0; t < NTAP; t++) begin
      w_r[t*PIX_W +: PIX_W] = w_win[t][R_MSB:R_LSB];
      w_g[t*PIX_W +: PIX_W] = w_win[t][G_MSB:G_LSB];
      w_b[t*PIX_W +: PIX_W] = w_win[t][B_MSB:B_LSB];
    end
  end

  assign w_adv = bus.iEn;

  // Kernel register loads on any edge with iCoefWe, stalled or not; a window
  // sampled on the same edge still sees the previous kernel.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst)            r_coef <= identity_kernel(SHIFT);
    else if (bus.iCoefWe) r_coef <= bus.iCoef;
  end

  // Valid chain matching the three datapath stages.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (w_adv) begin
      r_v1 <= bus.iValid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

  // A stalled result is only written on the edge that lets it leave stage 3.
  assign w_wr   = r_v3 & bus.iEn;
  assign w_last = (r_addr == LAST_ADDR);

  // Raster write address, wrapping after the last pixel of the frame.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst)       r_addr <= '0;
    else if (w_wr)   r_addr <= w_last ? '0 : r_addr + 1'b1;
  end

  conv3x3_rgb888_channel #(.SHIFT(SHIFT)) u_ch_r (
    .iClk(iClk), .iRst(iRst), .i_adv(w_adv), .i_pix(w_r), .i_coef(r_coef), .o_pix(w_pix_r)
  );
  conv3x3_rgb888_channel #(.SHIFT(SHIFT)) u_ch_g (
    .iClk(iClk), .iRst(iRst), .i_adv(w_adv), .i_pix(w_g), .i_coef(r_coef), .o_pix(w_pix_g)
  );
  conv3x3_rgb888_channel #(.SHIFT(SHIFT)) u_ch_b (
    .iClk(iClk), .iRst(iRst), .i_adv(w_adv), .i_pix(w_b), .i_coef(r_coef), .o_pix(w_pix_b)
  );

  assign w_pixel        = {w_pix_r, w_pix_g, w_pix_b};
  assign bus.oPixel     = w_pixel;
  assign bus.oValid     = w_wr;
  assign bus.oAddr      = r_addr;
  assign bus.oFrameDone = w_wr & w_last;

endmodule

// File: tb/tb_conv3x3_rgb888.sv
// Bench for conv3x3_rgb888: instance A uses the default frame with SHIFT=4,
// instance B a 4x3 frame with SHIFT=0; both receive identical stimulus.
module tb_conv3x3_rgb888;

  localparam int SHIFT_A = 4;
  localparam int SHIFT_B = 0;
  localparam int FRAME_A = 480 * 272;
  localparam int FRAME_B = 4 * 3;
  localparam logic [71:0] IDENT_A = 72'd16 << 32;
  localparam logic [71:0] IDENT_B = 72'd1 << 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        en = 1'b0, valid = 1'b0, cwe = 1'b0;
  logic [71:0] coef = '0;
  logic [23:0] win [9] = '{default: 24'h0};

  conv3x3_rgb888_if #(.DATA_W(24), .ADDR_W(17)) bus_a ();
  conv3x3_rgb888_if #(.DATA_W(24), .ADDR_W(17)) bus_b ();

  assign bus_a.iEn = en;      assign bus_b.iEn = en;
  assign bus_a.iValid = valid; assign bus_b.iValid = valid;
  assign bus_a.iCoefWe = cwe; assign bus_b.iCoefWe = cwe;
  assign bus_a.iCoef = coef;  assign bus_b.iCoef = coef;
  assign bus_a.iWin0 = win[0]; assign bus_b.iWin0 = win[0];
  assign bus_a.iWin1 = win[1]; assign bus_b.iWin1 = win[1];
  assign bus_a.iWin2 = win[2]; assign bus_b.iWin2 = win[2];
  assign bus_a.iWin3 = win[3]; assign bus_b.iWin3 = win[3];
  assign bus_a.iWin4 = win[4]; assign bus_b.iWin4 = win[4];
  assign bus_a.iWin5 = win[5]; assign bus_b.iWin5 = win[5];
  assign bus_a.iWin6 = win[6]; assign bus_b.iWin6 = win[6];
  assign bus_a.iWin7 = win[7]; assign bus_b.iWin7 = win[7];
  assign bus_a.iWin8 = win[8]; assign bus_b.iWin8 = win[8];

  conv3x3_rgb888 #(.SHIFT(SHIFT_A)) dut_a (.iClk(clk), .iRst(rst_n), .bus(bus_a));
  conv3x3_rgb888 #(.WIDTH(4), .HEIGHT(3), .SHIFT(SHIFT_B)) dut_b (.iClk(clk), .iRst(rst_n), .bus(bus_b));

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Plain arithmetic reference: per channel sum of pixel*coef, floor shift, clamp.
  function automatic logic [23:0] ref_pix(input logic [23:0] w [9], input logic [71:0] k, input int sh);
    logic [23:0] res;
    int acc, p;
    byte signed c;
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      acc = 0;
      for (int t = 0; t < 9; t++) begin
        c = k[t*8 +: 8];
        p = int'(w[t][ch*8 +: 8]);
        acc += p * int'(c);
      end
      acc = acc >>> sh;
      if (acc < 0) acc = 0;
      if (acc > 255) acc = 255;
      res[ch*8 +: 8] = 8'(acc);
    end
    return res;
  endfunction

  function automatic logic [71:0] mk_kernel(input logic [7:0] kc, input logic [7:0] ko);
    logic [71:0] k;
    for (int t = 0; t < 9; t++) k[t*8 +: 8] = (t == 4) ? kc : ko;
    return k;
  endfunction

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q_a[$], exp_q_b[$];
  int          tag_q_a[$], tag_q_b[$];
  int          adv = 0;
  logic [71:0] m_coef_a = IDENT_A, m_coef_b = IDENT_B;
  int          m_addr_a = 0, m_addr_b = 0;
  int          wr_a = 0, fd_b = 0;
  logic [16:0] last_addr_b = '0;

  // Model of accepted windows and the kernel register.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q_a.delete(); exp_q_b.delete(); tag_q_a.delete(); tag_q_b.delete();
      m_coef_a = IDENT_A; m_coef_b = IDENT_B;
      adv = 0; m_addr_a = 0; m_addr_b = 0;
    end else begin
      if (en) begin
        adv++;
        if (valid) begin
          exp_q_a.push_back(ref_pix(win, m_coef_a, SHIFT_A)); tag_q_a.push_back(adv);
          exp_q_b.push_back(ref_pix(win, m_coef_b, SHIFT_B)); tag_q_b.push_back(adv);
        end
      end
      if (cwe) begin
        m_coef_a = coef;
        m_coef_b = coef;
      end
    end
  end

  // A window accepted on advancing edge k is written during the cycle after
  // advancing edge k+2, provided iEn is high in that cycle.
  task automatic mon(input int id, input logic v, input logic [23:0] px, input logic [16:0] ad, input logic fd);
    logic ev;
    logic [23:0] ep;
    int ea, frame;
    string nm;
    nm = (id == 0) ? "a" : "b";
    frame = (id == 0) ? FRAME_A : FRAME_B;
    ep = '0;
    ea = 0;
    if (id == 0) ev = (exp_q_a.size() > 0) && (adv - tag_q_a[0] == 2) && en;
    else         ev = (exp_q_b.size() > 0) && (adv - tag_q_b[0] == 2) && en;
    if (ev || v) begin
      check({"valid_", nm}, 32'(v), 32'(ev));
      if (ev) begin
        if (id == 0) begin
          ep = exp_q_a.pop_front(); void'(tag_q_a.pop_front());
          ea = m_addr_a; m_addr_a = (m_addr_a + 1) % frame;
        end else begin
          ep = exp_q_b.pop_front(); void'(tag_q_b.pop_front());
          ea = m_addr_b; m_addr_b = (m_addr_b + 1) % frame;
        end
        if (v) begin
          check({"pixel_", nm}, 32'(px), 32'(ep));
          check({"addr_", nm}, 32'(ad), 32'(ea));
          check({"frame_done_", nm}, 32'(fd), 32'(ea == frame - 1));
        end
      end
    end else if (fd) begin
      check({"frame_done_idle_", nm}, 32'(fd), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, bus_a.oValid, bus_a.oPixel, bus_a.oAddr, bus_a.oFrameDone);
      mon(1, bus_b.oValid, bus_b.oPixel, bus_b.oAddr, bus_b.oFrameDone);
      if (bus_a.oValid) wr_a++;
      if (bus_b.oValid) last_addr_b = bus_b.oAddr;
      if (bus_b.oValid && bus_b.oFrameDone) fd_b++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_win();
    for (int t = 0; t < 9; t++) win[t] = 24'($urandom);
  endtask

  task automatic set_win(input logic [23:0] centre, input logic [23:0] neigh);
    for (int t = 0; t < 9; t++) win[t] = (t == 4) ? centre : neigh;
  endtask

  // Returns at the negedge where instance A first shows oValid, bounded.
  task automatic wait_out(input string name);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (bus_a.oValid) got = 1'b1;
    end
    if (!got) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  typedef struct packed {
    logic [23:0] centre;
    logic [23:0] neigh;
    logic [71:0] kern;
    logic [23:0] exp_a;
    logic [23:0] exp_b;
  } vec_t;

  vec_t        vecs [5];
  logic [23:0] x0 [9];
  logic [71:0] k_id16;
  logic [23:0] stall_exp;
  int          wr_before, fd_before, sent;

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{24'hFFFFFF, 24'hFFFFFF, mk_kernel(8'd1, 8'd1),    24'h8F8F8F, 24'hFFFFFF};
    vecs[1] = '{24'h000000, 24'h101010, mk_kernel(8'd8, 8'hFF),   24'h000000, 24'h000000};
    vecs[2] = '{24'h202020, 24'h000000, mk_kernel(8'd8, 8'hFF),   24'h101010, 24'hFFFFFF};
    vecs[3] = '{24'h123456, 24'hA5A5A5, mk_kernel(8'd16, 8'd0),   24'h123456, 24'hFFFFFF};
    vecs[4] = '{24'h000000, 24'h010203, mk_kernel(8'd1, 8'd1),    24'h000101, 24'h081018};
    k_id16 = mk_kernel(8'd16, 8'd0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pixel_a", 32'(bus_a.oPixel), 32'd0);
    check("rst_valid_a", 32'(bus_a.oValid), 32'd0);
    check("rst_addr_a", 32'(bus_a.oAddr), 32'd0);
    check("rst_fd_a", 32'(bus_a.oFrameDone), 32'd0);
    check("rst_addr_b", 32'(bus_b.oAddr), 32'd0);
    rst_n = 1'b1;
    tick();
    en = 1'b1;

    // Identity kernel straight out of reset, back-to-back windows
    for (int i = 0; i < 20; i++) begin
      valid = 1'b1;
      rand_win();
      tick();
    end
    valid = 1'b0;
    repeat (5) tick();

    // Table-driven kernels
    foreach (vecs[i]) begin
      coef = vecs[i].kern; cwe = 1'b1;
      tick();
      cwe = 1'b0; valid = 1'b1;
      set_win(vecs[i].centre, vecs[i].neigh);
      tick();
      valid = 1'b0;
      wait_out($sformatf("vec%0d", i));
      check($sformatf("vec%0d_pixel_a", i), 32'(bus_a.oPixel), 32'(vecs[i].exp_a));
      check($sformatf("vec%0d_pixel_b", i), 32'(bus_b.oPixel), 32'(vecs[i].exp_b));
      tick();
    end
    repeat (3) tick();

    // Stall with a finished pixel sitting in stage 3
    coef = k_id16; cwe = 1'b1;
    tick();
    cwe = 1'b0;
    valid = 1'b1;
    rand_win(); x0 = win;
    tick();
    rand_win();
    tick();
    rand_win();
    tick();
    valid = 1'b0; en = 1'b0;
    stall_exp = ref_pix(x0, k_id16, SHIFT_A);
    wr_before = wr_a;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid_a", 32'(bus_a.oValid), 32'd0);
      check("stall_hold_a", 32'(bus_a.oPixel), 32'(stall_exp));
      tick();
    end
    en = 1'b1;
    repeat (6) tick();
    check("stall_writes_a", 32'(wr_a - wr_before), 32'd3);

    // Kernel load on the same edge as a window
    coef = mk_kernel(8'd32, 8'd0); cwe = 1'b1;
    valid = 1'b1; set_win(24'h102030, 24'h000000);
    tick();
    cwe = 1'b0; set_win(24'h010203, 24'h000000);
    tick();
    valid = 1'b0;
    wait_out("coef_old");
    check("coef_old_pixel_a", 32'(bus_a.oPixel), 32'h102030);
    check("coef_old_pixel_b", 32'(bus_b.oPixel), 32'hFFFFFF);
    @(negedge clk);
    check("coef_new_valid_a", 32'(bus_a.oValid), 32'd1);
    check("coef_new_pixel_a", 32'(bus_a.oPixel), 32'h020406);
    check("coef_new_pixel_b", 32'(bus_b.oPixel), 32'h204060);
    tick();
    repeat (3) tick();

    // Random kernels, windows, bubbles, stalls and kernel loads
    for (int i = 0; i < 300; i++) begin
      en    = ($urandom_range(0, 9) != 0);
      valid = ($urandom_range(0, 3) != 0);
      cwe   = ($urandom_range(0, 19) == 0);
      coef  = {8'($urandom), 32'($urandom), 32'($urandom)};
      rand_win();
      tick();
    end
    en = 1'b1; valid = 1'b0; cwe = 1'b0;
    repeat (6) tick();

    // Small frame on instance B: 13 windows with bubbles, wrap after 12
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    fd_before = fd_b;
    sent = 0;
    while (sent < 13) begin
      valid = ($urandom_range(0, 2) != 0);
      if (valid) sent++;
      rand_win();
      tick();
    end
    valid = 1'b0;
    repeat (6) tick();
    check("small_frame_done_count_b", 32'(fd_b - fd_before), 32'd1);
    check("small_frame_next_addr_b", 32'(last_addr_b), 32'd0);

    // Asynchronous reset in the middle of a frame
    for (int i = 0; i < 6; i++) begin
      valid = 1'b1;
      rand_win();
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid_a", 32'(bus_a.oValid), 32'd0);
    check("async_rst_addr_a", 32'(bus_a.oAddr), 32'd0);
    check("async_rst_pixel_a", 32'(bus_a.oPixel), 32'd0);
    check("async_rst_addr_b", 32'(bus_b.oAddr), 32'd0);
    valid = 1'b0;
    tick();
    rst_n = 1'b1;
    valid = 1'b1;
    set_win(24'h3C5A78, 24'($urandom));
    tick();
    valid = 1'b0;
    wait_out("post_rst");
    check("post_rst_pixel_a", 32'(bus_a.oPixel), 32'h3C5A78);
    check("post_rst_pixel_b", 32'(bus_b.oPixel), 32'h3C5A78);
    check("post_rst_addr_a", 32'(bus_a.oAddr), 32'd0);
    tick();
    repeat (6) tick();

    check("leftover_a", 32'(exp_q_a.size()), 32'd0);
    check("leftover_b", 32'(exp_q_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time limit
  initial begin
    #300000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
